// File: rtl/matrix_pkg.sv
// ----------------------------------------------------------------------------
// matrix_pkg
//   Shared constants for the matrix memory datapath: element width, element
//   count and element address width, plus the serializer FSM state encoding.
// ----------------------------------------------------------------------------
package matrix_pkg;

    localparam int ELEM_W = 8;   // bits per matrix element
    localparam int N_ELEM = 9;   // elements per matrix (3x3, row-major)
    localparam int ADDR_W = 4;   // element address width, 2**ADDR_W >= N_ELEM

    // Serializer FSM encoding, kept as plain constants for legacy compatibility
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/matrix_result_serializer.sv
// ----------------------------------------------------------------------------
// matrix_result_serializer
//   Snapshots one flat N_ELEM-element matrix word and streams it out one
//   element per valid/ready transfer, tagged with the element address. The
//   stream maps straight onto a memory write port
//   (write_enable = out_valid && out_ready).
//
// Ports
//   clk       : system clock, everything on posedge
//   rst       : synchronous reset, active-high; overrides load and any stream
//   load      : snapshot request, honoured only when idle
//   mat_data  : flat matrix, element k = mat_data[k*ELEM_W +: ELEM_W]
//   busy      : high whenever the serializer is not idle
//   out_valid : out_addr/out_data/out_last are valid
//   out_ready : sink accepts the presented element
//   out_addr  : element index 0..N_ELEM-1
//   out_data  : element value
//   out_last  : high with element N_ELEM-1
//   done      : one-cycle pulse after the final transfer
// ----------------------------------------------------------------------------
module matrix_result_serializer
    import matrix_pkg::*;
#(
    parameter int ELEM_W_P = ELEM_W,
    parameter int N_ELEM_P = N_ELEM,
    parameter int ADDR_W_P = ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [ELEM_W_P*N_ELEM_P-1:0] mat_data,
    output logic                         busy,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W_P-1:0]          out_addr,
    output logic [ELEM_W_P-1:0]          out_data,
    output logic                         out_last,
    output logic                         done
);

    localparam logic [ADDR_W_P-1:0] LAST_IDX = ADDR_W_P'(N_ELEM_P - 1);

    logic [1:0]                   state_q, state_d;
    logic [ADDR_W_P-1:0]          idx_q, idx_d;
    logic [ELEM_W_P*N_ELEM_P-1:0] snap_q, snap_d;
    logic                         last_q, last_d;
    logic                         xfer;

    // out_valid is a pure decode of the state register, so the handshake
    // never depends combinationally on out_ready.
    assign xfer = (state_q == SEND) && out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    snap_d  = mat_data;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Registered so out_last lines up with the element it tags.
        last_d = (state_d == SEND) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            last_q  <= last_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == SEND);
    assign done      = (state_q == DONE);
    assign out_last  = last_q;
    assign out_addr  = idx_q;
    // Snapshot and index only change on load/transfer, so this mux is stable
    // while an element waits for out_ready.
    assign out_data  = snap_q[int'(idx_q)*ELEM_W_P +: ELEM_W_P];

endmodule

// File: tb/tb_matrix_result_serializer.sv
// ----------------------------------------------------------------------------
// tb_matrix_result_serializer
//   Self-checking bench for matrix_result_serializer: a table of directed
//   streams, a mid-stream reset sequence and randomized streams checked
//   against a queue-based model of the expected element sequence.
// ----------------------------------------------------------------------------
module tb_matrix_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [71:0] mat_data;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_addr;
    logic [7:0]  out_data;
    logic        out_last;
    logic        done;

    int checks = 0;
    int errors = 0;

    matrix_result_serializer #(
        .ELEM_W_P(8),
        .N_ELEM_P(9),
        .ADDR_W_P(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .mat_data (mat_data),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_addr (out_addr),
        .out_data (out_data),
        .out_last (out_last),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [71:0] mat;
        int          mode;        // 0: ready always, 1: ready 0,1,0,1..., 2: random
        bit          disturb;     // scramble mat_data and pulse load while busy
        int          exp_cycles;  // cycles from first valid to last transfer, -1 = any
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load matrix m, then follow the stream cycle by cycle. The expected
    // element sequence is simply the bytes of m captured at load time.
    task automatic run_stream(input logic [71:0] m, input int mode,
                              input bit disturb, input int exp_cycles);
        logic [7:0]  q[$];
        logic [95:0] junk;
        int          k;
        int          cyc;
        bit          r;
        for (int i = 0; i < 9; i++) q.push_back(m[i*8 +: 8]);
        mat_data = m;
        load     = 1'b1;
        tick();
        load = 1'b0;
        k    = 0;
        cyc  = 0;
        while (k < 9 && cyc < 300) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = cyc[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            if (disturb) begin
                junk     = {$urandom(), $urandom(), $urandom()};
                mat_data = cyc[1] ? '1 : junk[71:0];
                load     = ~cyc[0];
            end
            chk("valid", 32'(out_valid), 32'd1);
            chk("addr",  32'(out_addr),  32'(k));
            chk("data",  32'(out_data),  32'(q[k]));
            chk("last",  32'(out_last),  32'(k == 8));
            chk("done_in_send", 32'(done), 32'd0);
            chk("busy_in_send", 32'(busy), 32'd1);
            tick();
            if (r) k++;
            cyc++;
        end
        load      = disturb;  // a load during DONE must also be ignored
        out_ready = 1'b1;
        if (k < 9) chk("stream_timeout", 32'(k), 32'd9);
        if (exp_cycles >= 0) chk("cycles", 32'(cyc), 32'(exp_cycles));
        chk("done_pulse",  32'(done),      32'd1);
        chk("valid_done",  32'(out_valid), 32'd0);
        chk("busy_done",   32'(busy),      32'd1);
        tick();
        load = 1'b0;
        chk("done_clear",  32'(done),      32'd0);
        chk("busy_idle",   32'(busy),      32'd0);
        chk("valid_idle",  32'(out_valid), 32'd0);
        tick();
        chk("no_restream", 32'(out_valid), 32'd0);
        chk("still_idle",  32'(busy),      32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] rnd;
        logic [95:0] r96;

        tbl[0] = '{72'h09_08_07_06_05_04_03_02_01, 0, 1'b0, 9};
        tbl[1] = '{72'h09_08_07_06_05_04_03_02_01, 1, 1'b0, 18};
        tbl[2] = '{72'h09_08_07_06_05_04_03_02_01, 0, 1'b1, 9};
        tbl[3] = '{72'h90_80_70_60_50_40_30_20_10, 1, 1'b1, 18};

        // Reset held two cycles with load asserted
        rst       = 1'b1;
        load      = 1'b1;
        mat_data  = 72'h09_08_07_06_05_04_03_02_01;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_addr",  32'(out_addr),  32'd0);
        chk("rst_data",  32'(out_data),  32'd0);
        chk("rst_last",  32'(out_last),  32'd0);
        rst  = 1'b0;
        load = 1'b0;
        tick();
        chk("idle_after_rst", 32'(busy), 32'd0);

        for (int t = 0; t < 4; t++) begin
            run_stream(tbl[t].mat, tbl[t].mode, tbl[t].disturb, tbl[t].exp_cycles);
        end

        // Reset after four transfers abandons the stream
        mat_data  = 72'h09_08_07_06_05_04_03_02_01;
        load      = 1'b1;
        out_ready = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        chk("mid_addr4", 32'(out_addr), 32'd4);
        chk("mid_data5", 32'(out_data), 32'h05);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy",  32'(busy),      32'd0);
        chk("midrst_done",  32'(done),      32'd0);
        chk("midrst_addr",  32'(out_addr),  32'd0);
        chk("midrst_data",  32'(out_data),  32'd0);
        tick();
        chk("midrst_nodone",  32'(done),      32'd0);
        chk("midrst_novalid", 32'(out_valid), 32'd0);
        run_stream(72'h90_80_70_60_50_40_30_20_10, 0, 1'b0, 9);

        // Randomized streams with random backpressure
        for (int n = 0; n < 12; n++) begin
            r96 = {$urandom(), $urandom(), $urandom()};
            rnd = r96[71:0];
            run_stream(rnd, 2, 1'($urandom_range(0, 1)), -1);
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
